// File: rtl/wb_port_arbiter.sv
// rtl/wb_port_arbiter.sv - register-file write port arbiter between write-back and a queued MDU.
module wb_port_arbiter #(
  parameter int DEPTH    = 2,
  parameter int MAX_WAIT = 4,
  parameter int AW       = 5,
  parameter int DW       = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we_wb,
  input  logic [AW-1:0] wa_wb,
  input  logic [DW-1:0] wd_wb,
  input  logic          mdu_valid,
  input  logic [AW-1:0] mdu_wa,
  input  logic [DW-1:0] mdu_wd,
  output logic          mdu_ready,
  input  logic [AW-1:0] ra1,
  input  logic [AW-1:0] ra2,
  output logic          pend_hit,
  output logic          stall_o,
  output logic          rf_we,
  output logic [AW-1:0] rf_wa,
  output logic [DW-1:0] rf_wd,
  output logic          err_o
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam int SW = $clog2(MAX_WAIT + 1);

  logic [AW-1:0]    wa_mem [DEPTH];
  logic [DW-1:0]    wd_mem [DEPTH];
  logic [DEPTH-1:0] vld;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [CW-1:0]    count;
  logic [SW-1:0]    starve_cnt;

  logic p_req, empty, push, pop, starve_hit;

  assign p_req     = we_wb && (wa_wb != '0);
  assign empty     = (count == '0);
  assign mdu_ready = (count < CW'(DEPTH));
  // r0 results are acknowledged but never take a slot in the queue.
  assign push      = mdu_valid && mdu_ready && (mdu_wa != '0);
  assign pop       = !p_req && !empty;
  assign starve_hit = !stall_o && !empty && p_req && (starve_cnt == SW'(MAX_WAIT - 1));

  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    if (rst) begin
      if (p_req) begin
        rf_we = 1'b1;
        rf_wa = wa_wb;
        rf_wd = wd_wb;
      end else if (!empty) begin
        rf_we = 1'b1;
        rf_wa = wa_mem[rd_ptr];
        rf_wd = wd_mem[rd_ptr];
      end
    end
  end

  always_comb begin
    pend_hit = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (vld[i] && (((wa_mem[i] == ra1) && (ra1 != '0)) ||
                     ((wa_mem[i] == ra2) && (ra2 != '0))))
        pend_hit = 1'b1;
    end
  end

  // Payload storage needs no reset; the valid bits qualify every use.
  always_ff @(posedge clk) begin
    if (push) begin
      wa_mem[wr_ptr] <= mdu_wa;
      wd_mem[wr_ptr] <= mdu_wd;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      vld    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (pop) begin
        vld[rd_ptr] <= 1'b0;
        rd_ptr      <= rd_ptr + PW'(1);
      end
      if (push) begin
        vld[wr_ptr] <= 1'b1;
        wr_ptr      <= wr_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Freeze lasts exactly one cycle; a write-back during it is a protocol breach.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      starve_cnt <= '0;
      stall_o    <= 1'b0;
      err_o      <= 1'b0;
    end else if (stall_o) begin
      stall_o    <= 1'b0;
      starve_cnt <= '0;
      if (p_req)
        err_o <= 1'b1;
    end else if (empty || pop) begin
      starve_cnt <= '0;
    end else if (starve_hit) begin
      stall_o    <= 1'b1;
      starve_cnt <= '0;
    end else begin
      starve_cnt <= starve_cnt + SW'(1);
    end
  end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// tb/tb_wb_port_arbiter.sv - self-checking bench for wb_port_arbiter.
module tb_wb_port_arbiter;
  localparam int DEPTH = 2, MAX_WAIT = 4, AW = 5, DW = 32;

  logic clk = 1'b0, rst = 1'b0;
  logic we_wb = 0, mdu_valid = 0;
  logic [AW-1:0] wa_wb = 0, mdu_wa = 0, ra1 = 0, ra2 = 0;
  logic [DW-1:0] wd_wb = 0, mdu_wd = 0;
  logic mdu_ready, pend_hit, stall_o, rf_we, err_o;
  logic [AW-1:0] rf_wa;
  logic [DW-1:0] rf_wd;

  always #5 clk = ~clk;

  wb_port_arbiter #(.DEPTH(DEPTH), .MAX_WAIT(MAX_WAIT), .AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst), .we_wb(we_wb), .wa_wb(wa_wb), .wd_wb(wd_wb),
    .mdu_valid(mdu_valid), .mdu_wa(mdu_wa), .mdu_wd(mdu_wd), .mdu_ready(mdu_ready),
    .ra1(ra1), .ra2(ra2), .pend_hit(pend_hit), .stall_o(stall_o),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd), .err_o(err_o)
  );

  int n_tests = 0, n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a plain queue of pending results plus the starvation rule.
  typedef struct { logic [AW-1:0] wa; logic [DW-1:0] wd; } ent_t;
  ent_t mq[$];
  int   m_starve = 0;
  bit   m_stall = 0, m_err = 0;

  task automatic model_clear();
    mq.delete();
    m_starve = 0; m_stall = 0; m_err = 0;
  endtask

  task automatic model_check(input string tag);
    bit preq, e_we, e_pend;
    logic [AW-1:0] e_wa;
    logic [DW-1:0] e_wd;
    preq = we_wb && (wa_wb != 0);
    e_we = rst && (preq || mq.size() > 0);
    e_wa = 0; e_wd = 0; e_pend = 0;
    if (rst && preq) begin e_wa = wa_wb; e_wd = wd_wb; end
    else if (rst && mq.size() > 0) begin e_wa = mq[0].wa; e_wd = mq[0].wd; end
    foreach (mq[i])
      if ((ra1 != 0 && mq[i].wa == ra1) || (ra2 != 0 && mq[i].wa == ra2)) e_pend = 1;
    chk({tag, ".rf_we"}, rf_we, e_we);
    chk({tag, ".rf_wa"}, rf_wa, e_wa);
    chk({tag, ".rf_wd"}, rf_wd, e_wd);
    chk({tag, ".ready"}, mdu_ready, mq.size() < DEPTH);
    chk({tag, ".pend"}, pend_hit, e_pend);
    chk({tag, ".stall"}, stall_o, m_stall);
    chk({tag, ".err"}, err_o, m_err);
  endtask

  task automatic model_update();
    bit preq, pop, push;
    int n;
    ent_t e;
    if (!rst) return;
    preq = we_wb && (wa_wb != 0);
    n = mq.size();
    pop  = !preq && n > 0;
    push = mdu_valid && n < DEPTH && mdu_wa != 0;
    if (pop) void'(mq.pop_front());
    if (push) begin e.wa = mdu_wa; e.wd = mdu_wd; mq.push_back(e); end
    if (m_stall) begin
      m_err = m_err | preq; m_stall = 0; m_starve = 0;
    end else if (n == 0 || pop) begin
      m_starve = 0;
    end else begin
      m_starve++;
      if (m_starve == MAX_WAIT) begin m_stall = 1; m_starve = 0; end
    end
  endtask

  task automatic step(input string tag);
    #2 model_check(tag);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic drive(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                       input logic [AW-1:0] r1, input logic [AW-1:0] r2);
    we_wb = we; wa_wb = wa; wd_wb = wd;
    mdu_valid = mv; mdu_wa = mwa; mdu_wd = mwd;
    ra1 = r1; ra2 = r2;
  endtask

  task automatic do_reset();
    rst = 0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    model_clear();
    repeat (2) @(negedge clk);
    rst = 1;
  endtask

  typedef struct {
    logic we; logic [AW-1:0] wa; logic [DW-1:0] wd;
    logic mv; logic [AW-1:0] mwa; logic [DW-1:0] mwd;
    logic [AW-1:0] r1, r2;
    logic e_we; logic [AW-1:0] e_wa; logic [DW-1:0] e_wd; logic e_rdy, e_pend;
  } vec_t;
  vec_t tbl[12];

  task automatic set_vec(input int i, input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                         input logic mv, input logic [AW-1:0] mwa, input logic [DW-1:0] mwd,
                         input logic [AW-1:0] r1, input logic [AW-1:0] r2,
                         input logic e_we, input logic [AW-1:0] e_wa, input logic [DW-1:0] e_wd,
                         input logic e_rdy, input logic e_pend);
    tbl[i] = '{we, wa, wd, mv, mwa, mwd, r1, r2, e_we, e_wa, e_wd, e_rdy, e_pend};
  endtask

  initial begin
    //          we wa  wd    mv mwa mwd   r1 r2  ewe ewa ewd  rdy pend
    set_vec(0,  0, 0,  0,    1, 8,  'h11, 8, 0,  0,  0,  0,    1, 0);
    set_vec(1,  0, 0,  0,    0, 0,  0,    8, 0,  1,  8,  'h11, 1, 1);
    set_vec(2,  0, 0,  0,    0, 0,  0,    8, 0,  0,  0,  0,    1, 0);
    set_vec(3,  1, 1,  'hAA, 1, 4,  'h44, 8, 0,  1,  1,  'hAA, 1, 0);
    set_vec(4,  1, 1,  'hAA, 1, 6,  'h66, 4, 0,  1,  1,  'hAA, 1, 1);
    set_vec(5,  0, 0,  0,    1, 7,  'h77, 6, 0,  1,  4,  'h44, 0, 1);
    set_vec(6,  0, 0,  0,    1, 7,  'h77, 7, 6,  1,  6,  'h66, 1, 1);
    set_vec(7,  0, 0,  0,    1, 2,  'h22, 2, 0,  1,  7,  'h77, 1, 0);
    set_vec(8,  0, 0,  0,    0, 0,  0,    2, 0,  1,  2,  'h22, 1, 1);
    set_vec(9,  0, 0,  0,    1, 5,  'h55, 0, 5,  0,  0,  0,    1, 0);
    set_vec(10, 1, 0,  'hEE, 1, 0,  'h99, 0, 5,  1,  5,  'h55, 1, 1);
    set_vec(11, 0, 0,  0,    0, 0,  0,    0, 5,  0,  0,  0,    1, 0);

    // Reset state
    #1 chk("rst.rf_we", rf_we, 0);
    chk("rst.stall", stall_o, 0);
    chk("rst.err", err_o, 0);
    do_reset();
    #1 chk("post_rst.ready", mdu_ready, 1);

    foreach (tbl[i]) begin
      drive(tbl[i].we, tbl[i].wa, tbl[i].wd, tbl[i].mv, tbl[i].mwa, tbl[i].mwd, tbl[i].r1, tbl[i].r2);
      #1;
      chk($sformatf("vec%0d.rf_we", i), rf_we, tbl[i].e_we);
      chk($sformatf("vec%0d.rf_wa", i), rf_wa, tbl[i].e_wa);
      chk($sformatf("vec%0d.rf_wd", i), rf_wd, tbl[i].e_wd);
      chk($sformatf("vec%0d.ready", i), mdu_ready, tbl[i].e_rdy);
      chk($sformatf("vec%0d.pend", i), pend_hit, tbl[i].e_pend);
      chk($sformatf("vec%0d.stall", i), stall_o, 0);
      step($sformatf("vec%0d.mdl", i));
    end

    // Forced drain with a well-behaved pipeline, then with a protocol breach
    for (int pass = 0; pass < 2; pass++) begin
      do_reset();
      drive(0, 0, 0, 1, 3, 'h33, 3, 0);
      step("drain.push");
      for (int k = 0; k < MAX_WAIT; k++) begin
        drive(1, 9, 'h99, 0, 0, 0, 3, 0);
        #1 chk("drain.no_stall", stall_o, 0);
        chk("drain.pend", pend_hit, 1);
        step("drain.busy");
      end
      if (pass == 0) drive(0, 0, 0, 0, 0, 0, 3, 0);
      else           drive(1, 9, 'h99, 0, 0, 0, 3, 0);
      #1 chk("drain.stall", stall_o, 1);
      chk("drain.rf_wa", rf_wa, (pass == 0) ? 3 : 9);
      step("drain.stall_cyc");
      drive(0, 0, 0, 0, 0, 0, 3, 0);
      #1 chk("drain.stall_clr", stall_o, 0);
      chk("drain.err", err_o, pass);
      chk("drain.left_q", rf_we, pass);
      step("drain.after");
      #1 chk("drain.err_sticky", err_o, pass);
      step("drain.after2");
    end

    // Reset mid-operation with two entries queued
    do_reset();
    drive(1, 1, 'hAA, 1, 10, 'hA0, 10, 11);
    step("mid.push1");
    drive(1, 1, 'hAA, 1, 11, 'hB0, 10, 11);
    step("mid.push2");
    drive(1, 1, 'hAA, 0, 0, 0, 10, 11);
    #1 chk("mid.full", mdu_ready, 0);
    chk("mid.pend_before", pend_hit, 1);
    rst = 0;
    model_clear();
    #1 chk("mid.rf_we", rf_we, 0);
    chk("mid.stall", stall_o, 0);
    chk("mid.pend", pend_hit, 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1;
    drive(0, 0, 0, 0, 0, 0, 10, 11);
    #1 chk("mid.ready", mdu_ready, 1);
    chk("mid.empty", rf_we, 0);
    step("mid.after");

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      logic we;
      we = m_stall ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 99) < 55);
      drive(we, AW'($urandom_range(0, 7)), DW'($urandom),
            $urandom_range(0, 1), AW'($urandom_range(0, 7)), DW'($urandom),
            AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));
      step("rand");
      if (c == 300) do_reset();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/wb_port_arbiter.md
Name: wb_port_arbiter

Overview:
- Shares the single register-file write port between the pipeline write-back stage and a multi-cycle unit (MDU: mul/div, late loads).
- MDU results are queued in a DEPTH-entry FIFO and drain into write-port slots the pipeline leaves idle.
- Bounded starvation: after MAX_WAIT lost slots, the arbiter requests one pipeline freeze cycle to force a drain.
- Exports a pending-write hit so the hazard unit can stall reads of registers still owned by the MDU.

Parameters:
DEPTH, 2, MDU result FIFO entries (power of two, >=2)
MAX_WAIT, 4, consecutive lost arbitration cycles before forced drain (>=1)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
we_wb  input  1  pipeline write-back write enable
wa_wb  input  AW  pipeline write-back address
wd_wb  input  DW  pipeline write-back data
mdu_valid  input  1  MDU result valid
mdu_wa  input  AW  MDU destination register
mdu_wd  input  DW  MDU result data
mdu_ready  output  1  FIFO can accept an MDU result
ra1  input  AW  hazard-check address 1 (rs)
ra2  input  AW  hazard-check address 2 (rt)
pend_hit  output  1  ra1 or ra2 (non-zero) matches a queued entry
stall_o  output  1  registered freeze request to pipeline
rf_we  output  1  register-file write enable
rf_wa  output  AW  register-file write address
rf_wd  output  DW  register-file write data
err_o  output  1  sticky protocol error

Behaviour:
- Reset (rst=0, async): FIFO empty, count=0, starve_cnt=0, stall_o=0, err_o=0; rf_we forced 0 while rst=0; mdu_ready=1 after release.
- Pipeline request valid: p_req = we_wb && wa_wb!=0. Writes to r0 are never issued on the port.
- Grant (combinational, same cycle): p_req -> rf_we=1, rf_wa/rf_wd = wa_wb/wd_wb. Else FIFO non-empty -> rf_we=1, port driven from head entry, head popped at the clock edge. Else rf_we=0; rf_wa/rf_wd = 0.
- Push: mdu_valid && mdu_ready. mdu_ready = (count<DEPTH), with no same-cycle pop credit. Push with mdu_wa=0 is accepted and discarded (no entry stored).
- Simultaneous push and pop: count unchanged, pointers both advance. Pointers wrap modulo DEPTH.
- starve_cnt: increments when FIFO non-empty and p_req=1; clears on any pop or when FIFO empty.
- Forced drain: when starve_cnt would reach MAX_WAIT, set stall_o=1 at that edge and clear starve_cnt.
- In the stall_o=1 cycle the pipeline holds we_wb=0, the head drains, and stall_o clears at the next edge. stall_o is never high two consecutive cycles.
- Protocol error: p_req=1 while stall_o=1 -> pipeline still wins, no pop, err_o set sticky until reset; stall_o clears anyway and starve_cnt restarts from 0.
- pend_hit: OR over valid entries of (entry.wa==ra1 && ra1!=0) || (entry.wa==ra2 && ra2!=0). Combinational from stored entries only. An entry popped this cycle still counts this cycle; an entry pushed this cycle counts from the next cycle.
- Ordering: entries drain strictly FIFO. WAW/RAW ordering against the pipeline is the hazard unit's duty, using pend_hit.
- Reset mid-operation: queued entries are lost and no write is issued.

Test Plan:
- Idle pipeline; push (wa=8, wd=0x11) -> next cycle rf_we=1, rf_wa=8, rf_wd=0x11; pend_hit=1 for ra1=8 during the queued cycle, 0 after the pop.
- Push two entries, then push with mdu_valid held: mdu_ready=0 while count=2. Pop while pushing: count stays 1 after each cycle; entries drain in order.
- Queue wa=3, hold p_req=1 (wa=9) four cycles -> stall_o=1 on cycle 5; drop we_wb -> rf_wa=3 written, stall_o=0 next cycle, err_o=0.
- Same as above but keep we_wb=1 during stall_o -> rf_wa=9 written, err_o=1 sticky, entry still queued, stall_o=0 next cycle.
- we_wb=1, wa_wb=0 with FIFO holding wa=5 -> rf_we=1, rf_wa=5; MDU push with mdu_wa=0 -> count unchanged.
- Pull rst low with 2 entries queued -> rf_we=0, stall_o=0, pend_hit=0 immediately; after release mdu_ready=1 and count=0.
